multicycle_controller: RTL

Control FSM for the multicycle RV32I-subset core (lw, sw, R-type, I-type ALU, beq, jal). It sequences a shared datapath through fetch, decode and execute states. It drives the PC/IR/register-file/memory write enables and the ALU operand-mux selects, and stalls on a single-port memory handshake. ALU decoding is delegated to the existing `aludec`.

---
 rtl/riscv_mc_pkg.sv | 49 ++++
 rtl/multicycle_controller_if.sv | 15 +
 rtl/aludec.sv | 45 ++++
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared definitions for the multicycle RV32I-subset core control path.
// Holds the 4-bit FSM state encoding, the supported opcodes and the
// select-field codes for the ALU operation class, the result mux, the
// ALU operand muxes and the immediate-format selector.
package riscv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Single-port memory handshake between the controller and the memory.
//   MemReq   : controller requests an access this cycle
//   AdrSrc   : address select, 0 = PC, 1 = ALUOut
//   MemWrite : write strobe, held for the whole access
//   MemReady : memory completes the current access this cycle
// master = controller side, slave = memory side.
interface multicycle_controller_if;
  logic MemReq;
  logic AdrSrc;
  logic MemWrite;
  logic MemReady;

  modport master (output MemReq, output AdrSrc, output MemWrite, input MemReady);
  modport slave  (input MemReq, input AdrSrc, input MemWrite, output MemReady);
endinterface

// File: rtl/aludec.sv
// ALU decoder: maps the controller's ALU operation class plus the
// instruction funct fields to the 3-bit ALUControl code.
//   opb5       : opcode bit 5 (distinguishes R-type from I-type)
//   funct3     : Instr[14:12]
//   funct7b5   : Instr[30]
//   ALUOp      : 00 add, 01 sub, 10 decode from funct fields
//   ALUControl : 000 add, 001 sub, 010 and, 011 or, 101 slt
module aludec (
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] ALUOp,
  output logic [2:0] ALUControl
);

  logic rtype_sub_s;

  // Only R-type uses Instr[30] to select subtract; addi with imm[10]=1 stays add.
  assign rtype_sub_s = funct7b5 & opb5;

  // ALU operation decode.
  always_comb begin
    ALUControl = 3'b000;
    case (ALUOp)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000: begin
            if (rtype_sub_s) begin
              ALUControl = 3'b001;
            end else begin
              ALUControl = 3'b000;
            end
          end
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I-subset core (lw, sw, R-type,
// I-type ALU, beq, jal). Sequences the shared datapath through fetch,
// decode and execute states and stalls on the memory handshake.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   op/funct3/funct7b5  : instruction fields from IR
//   Zero                : ALU zero flag (branch decision)
//   mem                 : memory handshake (MemReq/AdrSrc/MemWrite/MemReady)
//   IRWrite/PCWrite/RegWrite : architectural write enables
//   ResultSrc/ALUSrcA/ALUSrcB : datapath mux selects
//   ImmSrc/ALUControl   : immediate format and ALU operation
//   Illegal             : one-cycle pulse for an unsupported opcode
module multicycle_controller
  import riscv_mc_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [6:0]                     op,
  input  logic [2:0]                     funct3,
  input  logic                           funct7b5,
  input  logic                           Zero,
  multicycle_controller_if.master        mem,
  output logic                           IRWrite,
  output logic                           PCWrite,
  output logic                           RegWrite,
  output logic [1:0]                     ResultSrc,
  output logic [1:0]                     ALUSrcA,
  output logic [1:0]                     ALUSrcB,
  output logic [1:0]                     ImmSrc,
  output logic [2:0]                     ALUControl,
  output logic                           Illegal
);

  state_t     state_r;
  state_t     state_next_s;

  logic       mem_req_s;
  logic       adr_src_s;
  logic       mem_write_s;
  logic       ir_write_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       reg_write_s;
  logic       illegal_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (mem.MemReady) begin
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = S_EXECUTER;
          OP_I:         state_next_s = S_EXECUTEI;
          OP_BEQ:       state_next_s = S_BEQ;
          OP_JAL:       state_next_s = S_JAL;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (mem.MemReady) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (mem.MemReady) begin
          state_next_s = S_FETCH;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMWB:    state_next_s = S_FETCH;
      S_EXECUTER: state_next_s = S_ALUWB;
      S_EXECUTEI: state_next_s = S_ALUWB;
      S_ALUWB:    state_next_s = S_FETCH;
      S_BEQ:      state_next_s = S_FETCH;
      S_JAL:      state_next_s = S_ALUWB;
      default:    state_next_s = S_FETCH;
    endcase
  end

  // Output decode; Moore except the FETCH handshake and DECODE illegal flag.
  always_comb begin
    mem_req_s    = 1'b0;
    adr_src_s    = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    reg_write_s  = 1'b0;
    illegal_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RS2;
    alu_op_s     = ALUOP_ADD;
    case (state_r)
      S_FETCH: begin
        mem_req_s    = 1'b1;
        result_src_s = RES_ALURESULT;
        alu_src_b_s  = SRCB_FOUR;
        // IR/PC load only on the completing cycle, so a stall still gives one pulse.
        ir_write_s   = mem.MemReady;
        pc_update_s  = mem.MemReady;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_s = 1'b0;
          default:                                  illegal_s = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_A;
        alu_src_b_s = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req_s = 1'b1;
        adr_src_s = 1'b1;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_s   = 1'b1;
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a_s = SRCA_A;
        alu_src_b_s = SRCB_RS2;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a_s = SRCA_A;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src_s = RES_ALUOUT;
        reg_write_s  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_s = SRCA_A;
        alu_src_b_s = SRCB_RS2;
        alu_op_s    = ALUOP_SUB;
        branch_s    = 1'b1;
      end
      S_JAL: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_update_s = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Immediate format decoder.
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  aludec u_aludec (
    .opb5       (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .ALUOp      (alu_op_s),
    .ALUControl (ALUControl)
  );

  // Enables are gated by reset_n so a reset mid-instruction suppresses writes at once;
  // selects already show FETCH values because the state is forced there.
  assign mem.MemReq   = mem_req_s & reset_n;
  assign mem.AdrSrc   = adr_src_s;
  assign mem.MemWrite = mem_write_s & reset_n;
  assign IRWrite      = ir_write_s & reset_n;
  assign PCWrite      = ((branch_s & Zero) | pc_update_s) & reset_n;
  assign RegWrite     = reg_write_s & reset_n;
  assign Illegal      = illegal_s & reset_n;
  assign ResultSrc    = result_src_s;
  assign ALUSrcA      = alu_src_a_s;
  assign ALUSrcB      = alu_src_b_s;

endmodule
